// File: rtl/seq_divider32_if.sv
// seq_divider32_if
//   Handshake/data bundle between the EX-stage pipeline and seq_divider32.
//   master : pipeline side (drives operands, op, flush, out_ready)
//   slave  : divider side  (drives in_ready, out_valid, result)
//   in_valid/in_ready    operand handshake
//   dividend/divisor/op  operands and operation (00 DIV, 01 DIVU, 10 REM, 11 REMU)
//   flush                abort any operation in flight
//   out_valid/out_ready  result handshake
//   result               quotient or remainder
interface seq_divider32_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [1:0]       op;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;

    modport master (
        output in_valid, dividend, divisor, op, flush, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, dividend, divisor, op, flush, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/seq_divider32.sv
// seq_divider32
//   Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//   One bit of quotient per cycle; one operation in flight.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    seq_divider32_if.slave (operand and result handshakes, flush)
//   Build option:
//     DIV_EARLY_OUT_EN  when defined, divide-by-zero, signed overflow and
//                       unsigned dividend < divisor finish straight from IDLE.
//                       Result values are identical either way.
//
//   state  | meaning
//   IDLE   | in_ready=1, waiting for an operation
//   PREP   | take magnitudes for signed ops, record result signs/special cases
//   ITER   | one shift/subtract step per cycle, WIDTH cycles
//   FIX    | apply signs and special-case overrides, select quo or rem
//   DONE   | out_valid=1, hold result until out_ready
module seq_divider32 #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider32_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] a_q,       a_d;       // original dividend, kept for overrides
    logic [WIDTH-1:0] b_q,       b_d;       // divisor, magnitude after PREP
    logic [WIDTH-1:0] quo_q,     quo_d;
    logic [WIDTH-1:0] rem_q,     rem_d;
    logic [WIDTH-1:0] result_q,  result_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [1:0]       op_q,      op_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div0_q,    div0_d;
    logic             ovf_q,     ovf_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    // Partial remainder after the shift can need WIDTH+1 bits; the sign of the
    // WIDTH+1-bit difference tells whether the divisor fits.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, b_q};

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        ovf_d     = ovf_q;
        sign_a    = !op_q[0] && a_q[WIDTH-1];
        sign_b    = !op_q[0] && b_q[WIDTH-1];
        quo_fix   = neg_quo_q ? -quo_q : quo_q;
        rem_fix   = neg_rem_q ? -rem_q : rem_q;

        if (div0_q) begin
            quo_fix = '1;
            rem_fix = a_q;
        end else if (ovf_q) begin
            quo_fix = a_q;
            rem_fix = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.dividend;
                    b_d     = bus.divisor;
                    op_d    = bus.op;
                    state_d = S_PREP;
`ifdef DIV_EARLY_OUT_EN
                    if (bus.divisor == '0) begin
                        result_d = bus.op[1] ? bus.dividend : '1;
                        state_d  = S_DONE;
                    end else if (!bus.op[0] && bus.dividend == MIN_NEG && bus.divisor == '1) begin
                        result_d = bus.op[1] ? '0 : bus.dividend;
                        state_d  = S_DONE;
                    end else if (bus.op[0] && bus.dividend < bus.divisor) begin
                        result_d = bus.op[1] ? bus.dividend : '0;
                        state_d  = S_DONE;
                    end
`endif
                end
            end
            S_PREP: begin
                quo_d     = sign_a ? -a_q : a_q;
                b_d       = sign_b ? -b_q : b_q;
                rem_d     = '0;
                neg_quo_d = sign_a ^ sign_b;
                neg_rem_d = sign_a;
                div0_d    = (b_q == '0);
                ovf_d     = !op_q[0] && (a_q == MIN_NEG) && (b_q == '1);
                cnt_d     = CW'(WIDTH - 1);
                state_d   = S_ITER;
            end
            S_ITER: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_FIX: begin
                result_d = op_q[1] ? rem_fix : quo_fix;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pipeline kill beats everything except an idle accept.
        if (bus.flush && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            ovf_q     <= ovf_d;
        end
    end
endmodule
